prg_share_ctrl: RTL and testbench

//  Sequencer/arbiter sharing one 4-bit LFSR pseudo-random generator among NREQ requesters.

---
 rtl/prg_share_ctrl_if.sv | 38 +++
 rtl/prg_share_ctrl.sv | 141 ++++++++++++++
 tb/tb_prg_share_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/prg_share_ctrl_if.sv
// Handshake/bus bundle between prg_share_ctrl, its requesters and the shared LFSR.
// lockup_evt exists only when PRG_LOCKUP_RECOVER_EN is defined.
interface prg_share_ctrl_if #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic [NREQ-1:0] req;
    logic            reseed;
    logic            rnd_ready;
    logic [3:0]      lfsr_code;
    logic [NREQ-1:0] gnt;
    logic            rnd_valid;
    logic [W-1:0]    rnd_data;
    logic            lfsr_preset;
    logic            lfsr_en;
    logic            busy;
`ifdef PRG_LOCKUP_RECOVER_EN
    logic            lockup_evt;
`endif

    modport master (
        input  req, reseed, rnd_ready, lfsr_code,
        output gnt, rnd_valid, rnd_data, lfsr_preset, lfsr_en, busy
`ifdef PRG_LOCKUP_RECOVER_EN
        , output lockup_evt
`endif
    );

    modport slave (
        output req, reseed, rnd_ready, lfsr_code,
        input  gnt, rnd_valid, rnd_data, lfsr_preset, lfsr_en, busy
`ifdef PRG_LOCKUP_RECOVER_EN
        , input lockup_evt
`endif
    );
endinterface

// File: rtl/prg_share_ctrl.sv
// Round-robin sequencer sharing one 4-bit LFSR among NREQ requesters, gathering NIBBLES codes per word.
// Optional PRG_LOCKUP_RECOVER_EN: skip and re-preset on an all-zero LFSR code.
module prg_share_ctrl #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned NIBBLES = 4
) (
    input  logic             clk,
    input  logic             preset_n,
    prg_share_ctrl_if.master bus
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_GATHER,
        ST_DELIVER
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    data_q, data_d;
    logic            pend_q, pend_d;

    logic [PW-1:0]   sel_idx;
    logic            sel_found;
    logic            lock_hit;
    logic            preset_c, en_c, valid_c;

`ifdef PRG_LOCKUP_RECOVER_EN
    assign lock_hit       = (bus.lfsr_code == 4'h0);
    assign bus.lockup_evt = (state_q == ST_GATHER) && lock_hit;
`else
    assign lock_hit = 1'b0;
`endif

    // Round-robin search starting at ptr_q, wrapping modulo NREQ.
    always_comb begin
        int unsigned   j;
        logic [PW-1:0] jx;
        j         = 0;
        jx        = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j  = (32'(ptr_q) + i) % NREQ;
            jx = PW'(j);
            if (!sel_found && bus.req[jx]) begin
                sel_found = 1'b1;
                sel_idx   = jx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        pend_d   = pend_q;
        preset_c = 1'b0;
        en_c     = 1'b0;
        valid_c  = 1'b0;

        if (bus.reseed && (state_q != ST_IDLE))
            pend_d = 1'b1;

        case (state_q)
            ST_INIT: begin
                preset_c = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.reseed || pend_q) begin
                    pend_d  = 1'b0;
                    state_d = ST_INIT;
                end else if (sel_found) begin
                    gnt_d   = NREQ'(1) << sel_idx;
                    gidx_d  = sel_idx;
                    cnt_d   = '0;
                    state_d = ST_GATHER;
                end
            end
            ST_GATHER: begin
                if (lock_hit) begin
                    preset_c = 1'b1;
                end else begin
                    en_c   = 1'b1;
                    data_d = {data_q[W-5:0], bus.lfsr_code};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(NIBBLES - 1))
                        state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                valid_c = 1'b1;
                if (bus.rnd_ready) begin
                    gnt_d   = '0;
                    ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= ST_INIT;
            gnt_q   <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
        end
    end

    // State is INIT throughout reset, so lfsr_preset and busy read high while preset_n is low.
    assign bus.gnt         = gnt_q;
    assign bus.rnd_data    = data_q;
    assign bus.rnd_valid   = valid_c;
    assign bus.lfsr_preset = preset_c;
    assign bus.lfsr_en     = en_c;
    assign bus.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_prg_share_ctrl.sv
// Directed, table-driven bench for prg_share_ctrl with an LFSR stub fed from a code table.
module tb_prg_share_ctrl;
    logic clk = 1'b0;
    logic preset_n = 1'b0;

    prg_share_ctrl_if #(.NREQ(4), .NIBBLES(4)) bus ();

    prg_share_ctrl #(.NREQ(4), .NIBBLES(4)) u_dut (
        .clk      (clk),
        .preset_n (preset_n),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // LFSR stand-in: steps through tab whenever the controller steps or re-presets on lock-up.
    logic [3:0] tab [32];
    int         code_idx = 0;
    assign bus.lfsr_code = tab[code_idx % 32];
    always @(posedge clk) begin
`ifdef PRG_LOCKUP_RECOVER_EN
        if (bus.lfsr_en || bus.lockup_evt) code_idx <= code_idx + 1;
`else
        if (bus.lfsr_en) code_idx <= code_idx + 1;
`endif
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic put(input int k, input logic [3:0] v);
        tab[(code_idx + k) % 32] = v;
    endtask

    task automatic put_word(input logic [15:0] w);
        for (int k = 0; k < 4; k++) put(k, w[15-4*k -: 4]);
    endtask

    task automatic do_reset();
        preset_n = 1'b0;
        #2;
        chk("rst_preset", bus.lfsr_preset, 1);
        chk("rst_busy",   bus.busy, 1);
        chk("rst_gnt",    bus.gnt, 0);
        chk("rst_valid",  bus.rnd_valid, 0);
        chk("rst_data",   bus.rnd_data, 0);
        chk("rst_en",     bus.lfsr_en, 0);
        @(posedge clk);
        #1 preset_n = 1'b1;
        @(negedge clk);
        chk("init_preset", bus.lfsr_preset, 1);
        chk("init_busy",   bus.busy, 1);
        @(negedge clk);
        chk("idle_preset", bus.lfsr_preset, 0);
        chk("idle_busy",   bus.busy, 0);
        chk("idle_gnt",    bus.gnt, 0);
        chk("idle_valid",  bus.rnd_valid, 0);
        chk("idle_en",     bus.lfsr_en, 0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        early;
        int          hold;
        logic [15:0] codes;
        logic [3:0]  exp_gnt;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    // Entered at a negedge with the DUT idle; leaves at a negedge with the DUT idle again.
    task automatic run_txn(input vec_t v);
        put_word(v.codes);
        bus.req       = v.req;
        bus.rnd_ready = 1'b0;
        @(negedge clk);
        chk("gnt",       bus.gnt, v.exp_gnt);
        chk("gather_en", bus.lfsr_en, 1);
        bus.req       = 4'b0000;
        bus.rnd_ready = v.early;
        repeat (3) @(negedge clk);
        chk("valid_early", bus.rnd_valid, 0);
        @(negedge clk);
        chk("valid",    bus.rnd_valid, 1);
        chk("data",     bus.rnd_data, v.exp_data);
        chk("dlv_en",   bus.lfsr_en, 0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("hold_valid", bus.rnd_valid, 1);
            chk("hold_data",  bus.rnd_data, v.exp_data);
            chk("hold_gnt",   bus.gnt, v.exp_gnt);
            chk("hold_en",    bus.lfsr_en, 0);
        end
        bus.rnd_ready = 1'b1;
        @(negedge clk);
        bus.rnd_ready = 1'b0;
        chk("done_valid", bus.rnd_valid, 0);
        chk("done_gnt",   bus.gnt, 0);
        chk("done_busy",  bus.busy, 0);
        chk("done_data",  bus.rnd_data, v.exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        for (int k = 0; k < 32; k++) tab[k] = 4'h1;
        bus.req       = '0;
        bus.reseed    = 1'b0;
        bus.rnd_ready = 1'b0;

        // ptr evolves 0 -> 1 -> 2 -> 3 -> 0 -> 1 -> 1 -> 0 -> 2 across these rows.
        vecs[0] = '{4'b0001, 1'b0, 0, 16'h1234, 4'b0001, 16'h1234};
        vecs[1] = '{4'b1111, 1'b1, 0, 16'habcd, 4'b0010, 16'habcd};
        vecs[2] = '{4'b1111, 1'b1, 0, 16'h5678, 4'b0100, 16'h5678};
        vecs[3] = '{4'b1111, 1'b1, 0, 16'h9ef1, 4'b1000, 16'h9ef1};
        vecs[4] = '{4'b1111, 1'b1, 0, 16'h2468, 4'b0001, 16'h2468};
        vecs[5] = '{4'b0001, 1'b0, 5, 16'hc357, 4'b0001, 16'hc357};
        vecs[6] = '{4'b1001, 1'b0, 0, 16'h1122, 4'b1000, 16'h1122};
        vecs[7] = '{4'b0110, 1'b0, 1, 16'hfedc, 4'b0010, 16'hfedc};

        do_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Reseed mid-GATHER: word completes, then one INIT cycle before the next grant.
        put_word(16'h4321);
        bus.req = 4'b0010;
        @(negedge clk);
        chk("rs_gnt", bus.gnt, 4'b0010);
        bus.reseed = 1'b1;
        @(negedge clk);
        bus.reseed = 1'b0;
        repeat (2) @(negedge clk);
        chk("rs_valid_early", bus.rnd_valid, 0);
        @(negedge clk);
        chk("rs_valid", bus.rnd_valid, 1);
        chk("rs_data",  bus.rnd_data, 16'h4321);
        bus.rnd_ready = 1'b1;
        @(negedge clk);
        bus.rnd_ready = 1'b0;
        chk("rs_idle_busy",  bus.busy, 0);
        chk("rs_idle_gnt",   bus.gnt, 0);
        @(negedge clk);
        chk("rs_init_preset", bus.lfsr_preset, 1);
        chk("rs_init_gnt",    bus.gnt, 0);
        chk("rs_init_busy",   bus.busy, 1);
        @(negedge clk);
        chk("rs_post_preset", bus.lfsr_preset, 0);
        chk("rs_post_gnt",    bus.gnt, 0);
        put_word(16'h8765);
        @(negedge clk);
        chk("rs_regnt", bus.gnt, 4'b0010);
        bus.req = '0;
        repeat (4) @(negedge clk);
        chk("rs2_data", bus.rnd_data, 16'h8765);
        bus.rnd_ready = 1'b1;
        @(negedge clk);
        bus.rnd_ready = 1'b0;
        chk("rs2_busy", bus.busy, 0);

        // All-zero code inside GATHER (ptr=2, req 0100).
        put(0, 4'h1); put(1, 4'h0); put(2, 4'h2); put(3, 4'h3); put(4, 4'h4);
        bus.req = 4'b0100;
        @(negedge clk);
        chk("lk_gnt", bus.gnt, 4'b0100);
        bus.req = '0;
        @(negedge clk);
`ifdef PRG_LOCKUP_RECOVER_EN
        chk("lk_evt",    bus.lockup_evt, 1);
        chk("lk_preset", bus.lfsr_preset, 1);
        chk("lk_en",     bus.lfsr_en, 0);
        @(negedge clk);
        chk("lk_evt_off",    bus.lockup_evt, 0);
        chk("lk_preset_off", bus.lfsr_preset, 0);
        repeat (2) @(negedge clk);
        chk("lk_valid_early", bus.rnd_valid, 0);
        @(negedge clk);
        chk("lk_valid", bus.rnd_valid, 1);
        chk("lk_data",  bus.rnd_data, 16'h1234);
`else
        chk("zero_preset", bus.lfsr_preset, 0);
        chk("zero_en",     bus.lfsr_en, 1);
        repeat (3) @(negedge clk);
        chk("zero_valid", bus.rnd_valid, 1);
        chk("zero_data",  bus.rnd_data, 16'h1023);
`endif
        bus.rnd_ready = 1'b1;
        @(negedge clk);
        bus.rnd_ready = 1'b0;
        chk("lk_done_busy", bus.busy, 0);

        // Reset mid-GATHER discards the partial word and returns ptr to 0.
        put_word(16'h5555);
        bus.req = 4'b0001;
        @(negedge clk);
        chk("mr_gnt", bus.gnt, 4'b0001);
        bus.req = '0;
        repeat (2) @(negedge clk);
        do_reset();
        @(negedge clk);
        v = '{4'b1010, 1'b0, 0, 16'h3c5a, 4'b0010, 16'h3c5a};
        run_txn(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
